// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common data bus arbiter and its consumers.
package cdb_arbiter_pkg;

    localparam int CDB_NUM_REQ = 4;
    localparam int CDB_WIDTH   = 32;
    localparam int CDB_TAG_W   = 4;

    // Fixed source slots on the bus; index 3 is the spare port.
    localparam int CDB_SRC_BR    = 0;
    localparam int CDB_SRC_ALU   = 1;
    localparam int CDB_SRC_LSQ   = 2;
    localparam int CDB_SRC_SPARE = 3;

    typedef struct packed {
        logic                 valid;
        logic [CDB_TAG_W-1:0] tag;
        logic [CDB_WIDTH-1:0] data;
    } cdb_t;

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Generic combinational round-robin picker: first request at or above ptr_i, wrapping.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        int         cand;
        logic [IDX_W-1:0] cand_idx;
        gnt_o    = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDX_W'(cand);
            if (!valid_o && req_i[cand_idx]) begin
                valid_o        = 1'b1;
                gnt_o[cand_idx] = 1'b1;
                idx_o          = cand_idx;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: ROB-head override, round-robin fallback, registered one-cycle broadcast.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = CDB_NUM_REQ,
    parameter int WIDTH   = CDB_WIDTH,
    parameter int TAG_W   = CDB_TAG_W,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [TAG_W-1:0]                rob_head_tag,
    input  logic                            rob_empty,
    input  logic                            cdb_hold,
    input  logic                            flush,
    output logic                            cdb_valid,
    output logic [TAG_W-1:0]                cdb_tag,
    output logic [WIDTH-1:0]                cdb_data,
    output logic [SRC_W-1:0]                cdb_src
);

    cdb_t             cdb_q,  cdb_d;
    logic [SRC_W-1:0] src_q,  src_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0] head_match;
    logic [NUM_REQ-1:0] rr_gnt;
    logic [SRC_W-1:0]   rr_idx;
    logic               rr_any;
    logic [SRC_W-1:0]   ovr_idx;
    logic               ovr_hit;
    logic [SRC_W-1:0]   grant_idx;
    logic               grant_valid;
    logic [NUM_REQ-1:0] ready_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_head_match
            assign head_match[gi] = req_valid[gi] && (req_tag[gi] == rob_head_tag);
        end
    endgenerate

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (SRC_W)
    ) u_rr (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (rr_gnt),
        .idx_o   (rr_idx),
        .valid_o (rr_any)
    );

    // Lowest matching index wins when several sources carry the head tag.
    always_comb begin
        ovr_idx = '0;
        ovr_hit = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (head_match[i]) begin
                ovr_hit = 1'b1;
                ovr_idx = SRC_W'(i);
            end
        end
    end

    always_comb begin
        ready_vec   = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        rr_ptr_d    = rr_ptr_q;
        if (!rst || flush || cdb_hold) begin
            grant_valid = 1'b0;
        end else if (!rob_empty && ovr_hit) begin
            grant_valid        = 1'b1;
            grant_idx          = ovr_idx;
            ready_vec[ovr_idx] = 1'b1;
        end else if (rr_any) begin
            grant_valid = 1'b1;
            grant_idx   = rr_idx;
            ready_vec   = rr_gnt;
            rr_ptr_d    = (rr_idx == SRC_W'(NUM_REQ - 1)) ? '0 : rr_idx + 1'b1;
        end
    end

    // Payload fields hold on idle cycles; only valid drops.
    always_comb begin
        cdb_d       = cdb_q;
        cdb_d.valid = 1'b0;
        src_d       = src_q;
        if (grant_valid) begin
            cdb_d.valid = 1'b1;
            cdb_d.tag   = req_tag[grant_idx];
            cdb_d.data  = req_data[grant_idx];
            src_d       = grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_q    <= '0;
            src_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            cdb_q    <= cdb_d;
            src_q    <= src_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign req_ready = ready_vec;
    assign cdb_valid = cdb_q.valid & ~flush;
    assign cdb_tag   = cdb_q.tag;
    assign cdb_data  = cdb_q.data;
    assign cdb_src   = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomized checks of the CDB arbiter against a rule-level reference model.
module tb_cdb_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req_valid;
    logic [3:0][3:0]  req_tag;
    logic [3:0][31:0] req_data;
    logic [3:0]       req_ready;
    logic [3:0]       rob_head_tag;
    logic             rob_empty;
    logic             cdb_hold;
    logic             flush;
    logic             cdb_valid;
    logic [3:0]       cdb_tag;
    logic [31:0]      cdb_data;
    logic [1:0]       cdb_src;

    int errors = 0;
    int checks = 0;

    // Reference model: pointer plus the broadcast expected on the bus next.
    int          m_ptr;
    bit          m_bv;
    logic [3:0]  m_tag;
    logic [31:0] m_data;
    logic [1:0]  m_src;

    cdb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_tag      (req_tag),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rob_head_tag (rob_head_tag),
        .rob_empty    (rob_empty),
        .cdb_hold     (cdb_hold),
        .flush        (flush),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .cdb_src      (cdb_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic int model_grant(output bit ovr);
        ovr = 1'b0;
        if (flush || cdb_hold) return -1;
        if (!rob_empty) begin
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_tag[i] == rob_head_tag) begin
                    ovr = 1'b1;
                    return i;
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (req_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        m_bv   = 1'b0;
        m_tag  = '0;
        m_data = '0;
        m_src  = '0;
    endtask

    // Entered at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic run_cycle(input string name, output int g);
        bit         ovr;
        logic [3:0] exp_rdy;
        g = model_grant(ovr);
        exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        #3;
        check({name, ".req_ready"}, req_ready, exp_rdy);
        check({name, ".cdb_valid"}, cdb_valid, m_bv && !flush);
        if (m_bv && !flush) begin
            check({name, ".cdb_tag"},  cdb_tag,  m_tag);
            check({name, ".cdb_data"}, cdb_data, m_data);
            check({name, ".cdb_src"},  cdb_src,  m_src);
        end
        $display("[%0t] %s valid=%b ready=%b exp_grant=%0d cdb_valid=%b tag=%0h src=%0d",
                 $time, name, req_valid, req_ready, g, cdb_valid, cdb_tag, cdb_src);
        @(posedge clk);
        if (g >= 0) begin
            m_bv   = 1'b1;
            m_tag  = req_tag[g];
            m_data = req_data[g];
            m_src  = 2'(g);
            if (!ovr) m_ptr = (g + 1) % 4;
        end else begin
            m_bv = 1'b0;
        end
        #1;
    endtask

    task automatic set_src(input int i, input logic v, input logic [3:0] t, input logic [31:0] d);
        req_valid[i] = v;
        req_tag[i]   = t;
        req_data[i]  = d;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        int g;
        rst = 1'b0;
        req_valid = '0;
        req_tag = '0;
        req_data = '0;
        rob_head_tag = '0;
        rob_empty = 1'b1;
        cdb_hold = 1'b0;
        flush = 1'b0;
        model_reset();

        // Reset state, then idle after release.
        #2;
        check("reset.cdb_valid", cdb_valid, 1'b0);
        check("reset.req_ready", req_ready, 4'b0000);
        check("reset.cdb_tag",   cdb_tag,   4'h0);
        check("reset.cdb_data",  cdb_data,  32'h0);
        check("reset.cdb_src",   cdb_src,   2'd0);
        do_reset();
        repeat (2) run_cycle("idle", g);

        // Round-robin fairness with all sources valid, no override.
        for (int i = 0; i < 4; i++) set_src(i, 1'b1, 4'(i + 1), 32'hA000_0000 + i);
        repeat (5) run_cycle("rr_fair", g);

        // Asynchronous reset mid-cycle while a broadcast is on the bus.
        #3;
        rst = 1'b0;
        #1;
        check("async_rst.cdb_valid", cdb_valid, 1'b0);
        check("async_rst.req_ready", req_ready, 4'b0000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        req_valid = '0;
        run_cycle("post_rst", g);

        // Head-tag override with rr_ptr at 0.
        set_src(0, 1'b1, 4'd1, 32'h0000_1111);
        set_src(1, 1'b1, 4'd2, 32'h0000_2222);
        set_src(2, 1'b1, 4'd5, 32'h0000_5555);
        rob_head_tag = 4'd5;
        rob_empty = 1'b0;
        run_cycle("override", g);
        req_valid[2] = 1'b0;
        run_cycle("override_next", g);
        req_valid = '0;
        run_cycle("override_drain", g);

        // Same stimulus with an empty ROB: round-robin wins.
        do_reset();
        set_src(2, 1'b1, 4'd5, 32'h0000_5555);
        req_valid = 4'b0111;
        rob_empty = 1'b1;
        run_cycle("rob_empty", g);
        req_valid = '0;
        run_cycle("rob_empty_drain", g);

        // Grant source 1, then flush: no broadcast in flush cycle or the one after.
        req_valid = 4'b0010;
        run_cycle("pre_flush", g);
        req_valid = 4'b0100;
        flush = 1'b1;
        run_cycle("flush", g);
        flush = 1'b0;
        req_valid = '0;
        run_cycle("post_flush", g);

        // Hold keeps the request pending until it drops.
        req_valid = 4'b0100;
        cdb_hold = 1'b1;
        repeat (2) run_cycle("hold", g);
        cdb_hold = 1'b0;
        run_cycle("hold_release", g);
        req_valid = '0;
        run_cycle("hold_drain", g);

        // Single requester streams back-to-back.
        for (int n = 0; n < 3; n++) begin
            set_src(3, 1'b1, 4'(7 + n), 32'hC0DE_0000 + n);
            run_cycle("single", g);
        end
        req_valid = '0;
        run_cycle("single_drain", g);

        // Randomized traffic with sources that honour the handshake.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && $urandom_range(1, 0) == 1)
                    set_src(i, 1'b1, 4'($urandom), $urandom);
            end
            flush     = ($urandom_range(9, 0) == 0);
            cdb_hold  = ($urandom_range(7, 0) == 0);
            rob_empty = ($urandom_range(2, 0) == 0);
            rob_head_tag = ($urandom_range(1, 0) == 1) ? req_tag[$urandom_range(3, 0)]
                                                       : 4'($urandom);
            run_cycle("rand", g);
            if (g >= 0) req_valid[g] = 1'b0;
        end
        flush = 1'b0;
        cdb_hold = 1'b0;
        req_valid = '0;
        run_cycle("rand_drain", g);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
